insn_sequencer: RTL and testbench

- Front-end controller that feeds the microcode decoder block.
- Fetches the opcode and 0-3 operand bytes over a byte-wide memory request/acknowledge handshake, presents insn/d1/d2/d3, and drives the microcode step index `is` through the execute phase.
- Sits between the memory/LSU bus, the PC unit and the decoder. It owns instruction-boundary control: halt, stall and end-of-instruction.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/insn_sequencer_fetch_port.sv | 36 +++
 rtl/insn_sequencer.sv | 171 +++++++++++++++++
 tb/tb_insn_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared types and constants for the instruction front end
//                and the microcode decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Width of the operand-count field reported by the decoder
    localparam int LEN_W      = 2;

    // Microcode steps per opcode and the width of the step index
    localparam int SEQ_STEPS  = 8;
    localparam int SEQ_STEP_W = 3;

    // Sequencer control states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH_OP  = 3'd1,
        ST_DECODE    = 3'd2,
        ST_FETCH_OPR = 3'd3,
        ST_EXEC      = 3'd4
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/insn_sequencer_fetch_port.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_port
//  Description : Byte-wide memory request/acknowledge port. Holds the request
//                for as long as the owner stays in a fetch phase, presents the
//                PC as the fetch address and pulses pc_inc per accepted byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_port #(
    parameter int ADDR_W = 16
) (
    input  logic              rst,
    input  logic              i_fetch,
    input  logic [ADDR_W-1:0] i_pc_addr,
    input  logic              i_mem_ack,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_pc_inc,
    output logic              o_accept
);

    logic w_accept;

    // The owner only leaves its fetch phase on an accept, so the request is
    // naturally held until the acknowledge arrives.
    assign o_mem_req  = i_fetch;
    assign o_mem_addr = i_fetch ? i_pc_addr : '0;

    // An ack without a request is ignored; an ack coinciding with reset is
    // discarded so the PC does not advance for a byte that is never latched.
    assign w_accept   = i_fetch & i_mem_ack & ~rst;
    assign o_accept   = w_accept;
    assign o_pc_inc   = w_accept;

endmodule
`default_nettype wire

// File: rtl/insn_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : insn_sequencer
//  Description : Instruction front end. Fetches opcode and up to three operand
//                bytes, hands them to the microcode decoder and steps the
//                microcode index through execution.
//  Revision    : 1.0 - initial release
// ============================================================================
module insn_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16,
    parameter int STEPS  = SEQ_STEPS,
    parameter int STEP_W = SEQ_STEP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pc_inc,
    input  logic [LEN_W-1:0]  len_in,
    input  logic              uend,
    input  logic              stall,
    output logic [DATA_W-1:0] insn,
    output logic [DATA_W-1:0] d1,
    output logic [DATA_W-1:0] d2,
    output logic [DATA_W-1:0] d3,
    output logic [STEP_W-1:0] is,
    output logic              exec_en,
    output logic              busy,
    output logic              overrun
);

    localparam logic [STEP_W-1:0] c_is_last = STEP_W'(STEPS - 1);

    seq_state_t        r_state;
    seq_state_t        w_next;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_opr_cnt;
    logic [LEN_W-1:0]  w_cnt_inc;
    logic [DATA_W-1:0] r_insn;
    logic [DATA_W-1:0] r_d1;
    logic [DATA_W-1:0] r_d2;
    logic [DATA_W-1:0] r_d3;
    logic [STEP_W-1:0] r_is;
    logic [STEP_W-1:0] w_is_next;
    logic              r_overrun;
    logic              w_force_end;
    logic              w_fetch;
    logic              w_accept;

    assign w_fetch   = (r_state == ST_FETCH_OP) || (r_state == ST_FETCH_OPR);
    assign w_cnt_inc = r_opr_cnt + LEN_W'(1);

    fetch_port #(
        .ADDR_W     (ADDR_W)
    ) u_fetch_port (
        .rst        (rst),
        .i_fetch    (w_fetch),
        .i_pc_addr  (pc_addr),
        .i_mem_ack  (mem_ack),
        .o_mem_req  (mem_req),
        .o_mem_addr (mem_addr),
        .o_pc_inc   (pc_inc),
        .o_accept   (w_accept)
    );

    // Control state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state, step-index advance and forced-end detection
    always_comb begin
        w_next      = r_state;
        w_is_next   = r_is;
        w_force_end = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run) w_next = ST_FETCH_OP;
            end
            ST_FETCH_OP: begin
                if (w_accept) w_next = ST_DECODE;
            end
            ST_DECODE: begin
                w_next = (len_in == '0) ? ST_EXEC : ST_FETCH_OPR;
            end
            ST_FETCH_OPR: begin
                if (w_accept && (w_cnt_inc == r_len)) w_next = ST_EXEC;
            end
            ST_EXEC: begin
                // Stall freezes the index and masks uend in the same cycle
                if (!stall) begin
                    if (uend || (r_is == c_is_last)) begin
                        w_is_next   = '0;
                        w_force_end = ~uend;
                        w_next      = run ? ST_FETCH_OP : ST_IDLE;
                    end else begin
                        w_is_next   = r_is + STEP_W'(1);
                    end
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Opcode/operand latches, operand counter, step index and sticky overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len     <= '0;
            r_opr_cnt <= '0;
            r_insn    <= '0;
            r_d1      <= '0;
            r_d2      <= '0;
            r_d3      <= '0;
            r_is      <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_is <= w_is_next;
            if (w_force_end) r_overrun <= 1'b1;
            case (r_state)
                ST_FETCH_OP: begin
                    if (w_accept) begin
                        r_insn <= mem_rdata;
                        r_d1   <= '0;
                        r_d2   <= '0;
                        r_d3   <= '0;
                    end
                end
                ST_DECODE: begin
                    r_len     <= len_in;
                    r_opr_cnt <= '0;
                end
                ST_FETCH_OPR: begin
                    if (w_accept) begin
                        case (r_opr_cnt)
                            2'd0:    r_d1 <= mem_rdata;
                            2'd1:    r_d2 <= mem_rdata;
                            default: r_d3 <= mem_rdata;
                        endcase
                        r_opr_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign insn    = r_insn;
    assign d1      = r_d1;
    assign d2      = r_d2;
    assign d3      = r_d3;
    assign is      = r_is;
    assign exec_en = (r_state == ST_EXEC);
    assign busy    = (r_state != ST_IDLE);
    assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_insn_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_insn_sequencer
//  Description : Self-checking bench for insn_sequencer. A small memory, PC
//                and decoder model feed a table of instructions; expected
//                opcode/operand/execution results go through a scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_insn_sequencer;

    localparam int N = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [15:0] pc_addr;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        pc_inc;
    logic [1:0]  len_in;
    logic        uend;
    logic        stall;
    logic [7:0]  insn;
    logic [7:0]  d1;
    logic [7:0]  d2;
    logic [7:0]  d3;
    logic [2:0]  is;
    logic        exec_en;
    logic        busy;
    logic        overrun;

    always #5 clk = ~clk;

    insn_sequencer #(
        .DATA_W    (8),
        .ADDR_W    (16),
        .STEPS     (8),
        .STEP_W    (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .pc_addr   (pc_addr),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .pc_inc    (pc_inc),
        .len_in    (len_in),
        .uend      (uend),
        .stall     (stall),
        .insn      (insn),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .is        (is),
        .exec_en   (exec_en),
        .busy      (busy),
        .overrun   (overrun)
    );

    typedef struct {
        logic [7:0] op;
        int         len;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] b3;
        int         dly;        // cycles mem_ack is held off per byte
        int         uend_at;    // step at which uend is raised, -1 = never
        int         stall_at;
        int         stall_len;
        bit         stall_uend; // raise uend during the stall window too
        bit         run_after;  // run level during execution
        int         exp_cycles; // expected exec_en cycles
        bit         exp_ovr;    // expected overrun after this instruction
    } vec_t;

    typedef struct {
        logic [7:0] insn;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [7:0] d3;
        int         cycles;
        bit         ovr;
        int         incs;
    } exp_t;

    vec_t       vecs [N];
    exp_t       sb [$];
    exp_t       cur_exp;
    logic [7:0] mem [256];

    int errors = 0;
    int checks = 0;

    int nf = 0, cur = 0, left = 0, wait_cnt = 0, incs = 0;
    int ecyc = 0, e_is = 0, st_cnt = 0, idle_hold = 0;
    bit opc_phase = 1'b1, decode_next = 1'b0, prev_exec = 1'b0, done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of the memory/PC/decoder/microcode environment.
    // Entered and left at a falling edge.
    task automatic cycle();
        int vi;
        bit acc;
        vi = opc_phase ? ((nf < N) ? nf : N - 1) : cur;
        if (mem_req) begin
            mem_rdata = mem[pc_addr[7:0]];
            mem_ack   = (wait_cnt >= vecs[vi].dly);
        end else begin
            mem_rdata = 8'($urandom_range(0, 255));
            mem_ack   = 1'($urandom_range(0, 1));
        end
        len_in = decode_next ? 2'(vecs[cur].len) : 2'($urandom_range(0, 3));
        stall  = exec_en && (is == 3'(vecs[cur].stall_at)) && (st_cnt < vecs[cur].stall_len);
        uend   = exec_en && ((stall && vecs[cur].stall_uend) ||
                             (!stall && (int'(is) == vecs[cur].uend_at)));
        if (exec_en) begin
            run = vecs[cur].run_after;
        end else if (!busy) begin
            run = (idle_hold == 0) && (nf < N);
            if (idle_hold > 0) idle_hold--;
        end else begin
            run = 1'($urandom_range(0, 1));
        end
        #1;
        decode_next = 1'b0;
        acc = mem_req && mem_ack;
        if (mem_req) check("mem_addr", 64'(mem_addr), 64'(pc_addr));
        check("pc_inc", 64'(pc_inc), 64'(acc));

        if (exec_en && !prev_exec) begin
            if (sb.size() == 0) begin
                check("sb_nonempty", 64'(0), 64'(1));
            end else begin
                cur_exp = sb.pop_front();
                check("insn", 64'(insn), 64'(cur_exp.insn));
                check("d1", 64'(d1), 64'(cur_exp.d1));
                check("d2", 64'(d2), 64'(cur_exp.d2));
                check("d3", 64'(d3), 64'(cur_exp.d3));
                check("pc_inc_count", 64'(incs), 64'(cur_exp.incs));
            end
            e_is = 0;
            ecyc = 0;
        end
        if (exec_en) begin
            check("is", 64'(is), 64'(e_is));
            ecyc++;
            if (stall) st_cnt++;
            else       e_is++;
        end
        if (!exec_en && prev_exec) begin
            check("exec_cycles", 64'(ecyc), 64'(cur_exp.cycles));
            check("overrun", 64'(overrun), 64'(cur_exp.ovr));
            check("mem_req_after", 64'(mem_req), 64'(vecs[cur].run_after));
            check("busy_after", 64'(busy), 64'(vecs[cur].run_after));
            if (!vecs[cur].run_after) idle_hold = 3;
            if (cur == N - 1) done = 1'b1;
        end
        prev_exec = exec_en;

        if (acc) begin
            if (opc_phase) begin
                exp_t e;
                cur         = nf;
                nf++;
                incs        = 1;
                st_cnt      = 0;
                left        = vecs[cur].len;
                decode_next = 1'b1;
                opc_phase   = (left == 0);
                e.insn   = vecs[cur].op;
                e.d1     = (vecs[cur].len >= 1) ? vecs[cur].b1 : 8'h00;
                e.d2     = (vecs[cur].len >= 2) ? vecs[cur].b2 : 8'h00;
                e.d3     = (vecs[cur].len >= 3) ? vecs[cur].b3 : 8'h00;
                e.cycles = vecs[cur].exp_cycles;
                e.ovr    = vecs[cur].exp_ovr;
                e.incs   = vecs[cur].len + 1;
                sb.push_back(e);
            end else begin
                incs++;
                left--;
                if (left == 0) opc_phase = 1'b1;
            end
        end
        if (mem_req && !mem_ack) wait_cnt++;
        else                     wait_cnt = 0;

        @(posedge clk);
        #1;
        if (acc) pc_addr = pc_addr + 16'd1;
        @(negedge clk);
    endtask

    initial begin
        int a;
        rst = 1'b1; run = 1'b0; pc_addr = '0; mem_ack = 1'b0; mem_rdata = '0;
        len_in = '0; uend = 1'b0; stall = 1'b0;

        //            op     len b1     b2     b3    dly uend stA stL sU  run cyc ovr
        vecs[0] = '{8'h3A, 0, 8'h00, 8'h00, 8'h00, 0,  2, 0, 0, 1'b0, 1'b1, 3, 1'b0};
        vecs[1] = '{8'h41, 3, 8'h10, 8'h20, 8'h30, 2,  0, 0, 0, 1'b0, 1'b1, 1, 1'b0};
        vecs[2] = '{8'h52, 1, 8'h77, 8'h00, 8'h00, 1,  1, 1, 3, 1'b1, 1'b1, 5, 1'b0};
        vecs[3] = '{8'h60, 0, 8'h00, 8'h00, 8'h00, 0, -1, 0, 0, 1'b0, 1'b1, 8, 1'b1};
        vecs[4] = '{8'h61, 2, 8'hAA, 8'hBB, 8'h00, 0,  0, 0, 0, 1'b0, 1'b0, 1, 1'b1};
        vecs[5] = '{8'h7E, 0, 8'h00, 8'h00, 8'h00, 3,  4, 0, 0, 1'b0, 1'b1, 5, 1'b1};
        vecs[6] = '{8'h99, 2, 8'h01, 8'h02, 8'h00, 1,  1, 0, 0, 1'b0, 1'b0, 2, 1'b1};

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        a = 0;
        for (int i = 0; i < N; i++) begin
            mem[a] = vecs[i].op; a++;
            if (vecs[i].len >= 1) begin mem[a] = vecs[i].b1; a++; end
            if (vecs[i].len >= 2) begin mem[a] = vecs[i].b2; a++; end
            if (vecs[i].len >= 3) begin mem[a] = vecs[i].b3; a++; end
        end

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs",
              64'({mem_req, mem_addr, pc_inc, insn, d1, d2, d3, is, exec_en, busy, overrun}), 64'(0));

        // Reset while a fetch is acknowledged in the same cycle
        @(negedge clk);
        rst = 1'b0; run = 1'b1;
        @(negedge clk);
        #1;
        check("fetch_req", 64'(mem_req), 64'(1));
        mem_ack = 1'b1; mem_rdata = 8'h5A; rst = 1'b1;
        #1;
        check("rst_ack_pc_inc", 64'(pc_inc), 64'(0));
        @(negedge clk);
        mem_ack = 1'b0; rst = 1'b0; run = 1'b0;
        #1;
        check("rst_ack_outputs",
              64'({mem_req, mem_addr, pc_inc, d1, d2, d3, is, exec_en, busy, overrun}), 64'(0));
        check("rst_ack_insn", 64'(insn), 64'(0));
        @(negedge clk);

        // Table-driven instruction stream
        for (int c = 0; c < 3000 && !done; c++) cycle();
        check("stream_completed", 64'(done), 64'(1));
        check("scoreboard_drained", 64'(sb.size()), 64'(0));
        check("final_pc", 64'(pc_addr), 64'(a));
        check("final_idle", 64'({busy, mem_req}), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
